// File: rtl/cpu_ctrl_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_ctrl_pkg                                               |
// | Description : Shared constants and types for the accumulator-CPU control |
// |               sequencer: opcodes, ALU function codes, sequencer state    |
// |               enum, beat numbers and small decode helpers.               |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cpu_ctrl_pkg;

   // Full 8-bit instruction encodings; the opcode is the top nibble.
   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_ADD  = 8'h10;
   localparam logic [7:0] OP_SUB  = 8'h20;
   localparam logic [7:0] OP_AND  = 8'h30;
   localparam logic [7:0] OP_OR   = 8'h40;
   localparam logic [7:0] OP_XOR  = 8'h50;
   localparam logic [7:0] OP_INC  = 8'h60;
   localparam logic [7:0] OP_NOT  = 8'h70;
   localparam logic [7:0] OP_CLR  = 8'h80;
   localparam logic [7:0] OP_SHR  = 8'h90;
   localparam logic [7:0] OP_MVR  = 8'hA0;
   localparam logic [7:0] OP_JMP  = 8'hB0;
   localparam logic [7:0] OP_JPZ  = 8'hC0;
   localparam logic [7:0] OP_JPNZ = 8'hD0;
   localparam logic [7:0] OP_LAD  = 8'hE0;
   localparam logic [7:0] OP_STO  = 8'hF0;
   localparam logic [7:0] OP_HALT = 8'h0F;

   typedef logic [3:0] alus_t;

   localparam alus_t ALUS_NONE = 4'h0;
   localparam alus_t ALUS_CLR  = 4'h0;
   localparam alus_t ALUS_ADD  = 4'h1;
   localparam alus_t ALUS_SUB  = 4'h2;
   localparam alus_t ALUS_AND  = 4'h3;
   localparam alus_t ALUS_OR   = 4'h4;
   localparam alus_t ALUS_XOR  = 4'h5;
   localparam alus_t ALUS_INC  = 4'h6;
   localparam alus_t ALUS_NOT  = 4'h7;
   localparam alus_t ALUS_SHR  = 4'h9;
   localparam alus_t ALUS_LAD  = 4'hA;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [2:0] B0 = 3'd0;
   localparam logic [2:0] B1 = 3'd1;
   localparam logic [2:0] B2 = 3'd2;
   localparam logic [2:0] B3 = 3'd3;
   localparam logic [2:0] B4 = 3'd4;
   localparam logic [2:0] B5 = 3'd5;
   localparam logic [2:0] B6 = 3'd6;
   localparam logic [2:0] B7 = 3'd7;

   // Final beat of each instruction class; opc is the effective opcode
   // nibble (illegal encodings are already folded onto NOP).
   function automatic logic [2:0] last_beat(input logic [3:0] opc);
      case (opc)
         OP_NOP[7:4], OP_CLR[7:4], OP_MVR[7:4]:   return B3;
         OP_JMP[7:4], OP_JPZ[7:4], OP_JPNZ[7:4]:  return B5;
         OP_STO[7:4]:                             return B6;
         OP_LAD[7:4]:                             return B7;
         default:                                 return B4;
      endcase
   endfunction

   function automatic alus_t alus_of(input logic [3:0] opc);
      case (opc)
         OP_ADD[7:4]: return ALUS_ADD;
         OP_SUB[7:4]: return ALUS_SUB;
         OP_AND[7:4]: return ALUS_AND;
         OP_OR[7:4]:  return ALUS_OR;
         OP_XOR[7:4]: return ALUS_XOR;
         OP_INC[7:4]: return ALUS_INC;
         OP_NOT[7:4]: return ALUS_NOT;
         OP_CLR[7:4]: return ALUS_CLR;
         OP_SHR[7:4]: return ALUS_SHR;
         OP_LAD[7:4]: return ALUS_LAD;
         default:     return ALUS_NONE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_ctrl_seq_if                                            |
// | Description : Bundle between the control sequencer and the datapath /    |
// |               memory port.                                               |
// |               master : sequencer (drives enables, reads ir/z/mem_ready)  |
// |               slave  : datapath  (drives ir/z/mem_ready, reads enables)  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface cpu_ctrl_seq_if #(parameter int DW = 8);
   import cpu_ctrl_pkg::*;

   logic [DW-1:0] ir;
   logic          z;
   logic          mem_ready;

   logic pcbus, r0bus, r1bus, drlbus, drhbus, trbus, membus, busmem;
   logic r0load, r1load, zload, xload, arload, drload, irload, trload, pcload;
   logic pcinc, arinc, read, write;
   alus_t alus;

   modport master (
      input  ir, z, mem_ready,
      output pcbus, r0bus, r1bus, drlbus, drhbus, trbus, membus, busmem,
      output r0load, r1load, zload, xload, arload, drload, irload, trload, pcload,
      output pcinc, arinc, read, write, alus
   );

   modport slave (
      output ir, z, mem_ready,
      input  pcbus, r0bus, r1bus, drlbus, drhbus, trbus, membus, busmem,
      input  r0load, r1load, zload, xload, arload, drload, irload, trload, pcload,
      input  pcinc, arinc, read, write, alus
   );
endinterface
`default_nettype wire

// File: rtl/cpu_ctrl_seq_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ctrl_wait_timer                                            |
// | Description : Counts consecutive memory stall cycles within one beat and |
// |               flags expiry on the TIMEOUT-th stall cycle.                |
// | Ports       : clk, reset (async, active-low)                             |
// |               i_stall  - current beat is waiting on mem_ready            |
// |               o_expire - this cycle is the TIMEOUT-th consecutive stall  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ctrl_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic i_stall,
   output logic o_expire
);
   // Counter holds the number of earlier stall cycles (0..TIMEOUT-1).
   localparam int             c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

   logic [c_cnt_w-1:0] r_cnt;

   assign o_expire = i_stall && (r_cnt == c_last);

   // Any non-stall cycle is a beat advance (or idle), which restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (i_stall && !o_expire)
         r_cnt <= r_cnt + 1'b1;
      else
         r_cnt <= '0;
   end
endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_ctrl_seq                                               |
// | Description : Hardwired control sequencer for the 8-bit accumulator CPU. |
// |               Encoded beat counter with memory wait states, stall        |
// |               watchdog, HALT, latched branch condition, run/step gating. |
// | Ports       : clk, reset (async, active-low)                             |
// |               run, step       - execution gating                         |
// |               bus (master)    - ir/z/mem_ready in, enables/strobes out   |
// |               instr_done      - last-beat completion pulse               |
// |               halted, bus_err, illegal - sticky status                   |
// |               beat            - current beat (debug)                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cpu_ctrl_seq
   import cpu_ctrl_pkg::*;
#(
   parameter int DW      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           run,
   input  logic           step,
   cpu_ctrl_seq_if.master bus,
   output logic           instr_done,
   output logic           halted,
   output logic           bus_err,
   output logic           illegal,
   output logic [2:0]     beat
);
   state_t     r_state, w_state_nxt;
   logic [2:0] r_beat, w_beat_nxt;
   logic       r_cond, r_b3_first, r_bus_err, r_illegal;

   logic [3:0] w_opc, w_op;
   logic       w_is_halt, w_bad_low, w_cond, w_taken;
   logic       w_rd, w_wr, w_drl, w_pci, w_ari, w_trl;
   logic       w_stall, w_expire, w_done, w_set_ill;

   // Illegal low fields are folded onto NOP so they decode no enables.
   assign w_opc     = bus.ir[DW-1 -: 4];
   assign w_is_halt = (bus.ir == DW'(OP_HALT));
   assign w_bad_low = (bus.ir[DW-5:0] != '0) && !w_is_halt;
   assign w_op      = w_bad_low ? 4'h0 : w_opc;

   // On the first b3 cycle z is used live; afterwards the captured copy,
   // so z changes made by the instruction itself cannot flip the branch.
   assign w_cond  = r_b3_first ? bus.z : r_cond;
   assign w_taken = (w_op == OP_JMP[7:4]) ||
                    ((w_op == OP_JPZ[7:4])  &&  w_cond) ||
                    ((w_op == OP_JPNZ[7:4]) && !w_cond);

   // Enable/strobe decode from registered state (ungated memory-side loads).
   always_comb begin
      bus.pcbus  = 1'b0; bus.r0bus  = 1'b0; bus.r1bus  = 1'b0; bus.drlbus = 1'b0;
      bus.drhbus = 1'b0; bus.trbus  = 1'b0; bus.membus = 1'b0; bus.busmem = 1'b0;
      bus.r0load = 1'b0; bus.r1load = 1'b0; bus.zload  = 1'b0; bus.xload  = 1'b0;
      bus.arload = 1'b0; bus.irload = 1'b0; bus.pcload = 1'b0;
      bus.alus   = ALUS_NONE;
      w_rd = 1'b0; w_wr = 1'b0; w_drl = 1'b0; w_pci = 1'b0; w_ari = 1'b0; w_trl = 1'b0;
      if (r_state == ST_RUN) begin
         case (r_beat)
            B0: begin bus.pcbus = 1'b1; bus.arload = 1'b1; end
            B1: begin w_rd = 1'b1; bus.membus = 1'b1; w_drl = 1'b1; w_pci = 1'b1; end
            B2: begin bus.pcbus = 1'b1; bus.arload = 1'b1; bus.irload = 1'b1; end
            default: begin
               bus.alus = alus_of(w_op);
               case (w_op)
                  OP_ADD[7:4], OP_SUB[7:4], OP_AND[7:4], OP_OR[7:4], OP_XOR[7:4]: begin
                     if (r_beat == B3) begin bus.r0bus = 1'b1; bus.xload = 1'b1; end
                     else begin bus.r1bus = 1'b1; bus.r0load = 1'b1; bus.zload = 1'b1; end
                  end
                  OP_INC[7:4], OP_NOT[7:4], OP_SHR[7:4]: begin
                     if (r_beat == B3) begin bus.r0bus = 1'b1; bus.xload = 1'b1; end
                     else begin bus.r0load = 1'b1; bus.zload = 1'b1; end
                  end
                  OP_CLR[7:4]: begin bus.r0load = 1'b1; bus.zload = 1'b1; end
                  OP_MVR[7:4]: begin bus.r0bus = 1'b1; bus.r1load = 1'b1; end
                  OP_JMP[7:4], OP_JPZ[7:4], OP_JPNZ[7:4]: begin
                     if (w_taken) begin
                        case (r_beat)
                           B3: begin w_rd = 1'b1; bus.membus = 1'b1; w_drl = 1'b1; w_ari = 1'b1; end
                           B4: begin w_rd = 1'b1; bus.membus = 1'b1; w_drl = 1'b1; w_trl = 1'b1; end
                           default: begin bus.drhbus = 1'b1; bus.trbus = 1'b1; bus.pcload = 1'b1; end
                        endcase
                     end else if (r_beat != B5) begin
                        // Skip the two address bytes of the untaken branch.
                        w_pci = 1'b1;
                     end
                  end
                  OP_LAD[7:4], OP_STO[7:4]: begin
                     case (r_beat)
                        B3: begin w_rd = 1'b1; bus.membus = 1'b1; w_drl = 1'b1; w_pci = 1'b1; w_ari = 1'b1; end
                        B4: begin w_rd = 1'b1; bus.membus = 1'b1; w_drl = 1'b1; w_pci = 1'b1; w_trl = 1'b1; end
                        B5: begin bus.drhbus = 1'b1; bus.trbus = 1'b1; bus.arload = 1'b1; end
                        B6: begin
                           if (w_op == OP_LAD[7:4]) begin
                              w_rd = 1'b1; bus.membus = 1'b1; w_drl = 1'b1;
                           end else begin
                              bus.r0bus = 1'b1; bus.busmem = 1'b1; w_wr = 1'b1;
                           end
                        end
                        default: begin bus.drlbus = 1'b1; bus.r0load = 1'b1; end
                     endcase
                  end
                  default: ;
               endcase
            end
         endcase
      end
   end

   assign w_stall = (r_state == ST_RUN) && (w_rd || w_wr) && !bus.mem_ready;

   // Loads tied to a memory transfer fire only on the completing cycle.
   assign bus.read   = w_rd;
   assign bus.write  = w_wr;
   assign bus.drload = w_drl && !w_stall;
   assign bus.pcinc  = w_pci && !w_stall;
   assign bus.arinc  = w_ari && !w_stall;
   assign bus.trload = w_trl && !w_stall;

   ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .i_stall  (w_stall),
      .o_expire (w_expire)
   );

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_done      = 1'b0;
      w_set_ill   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (run || step) begin
               w_state_nxt = ST_RUN;
               w_beat_nxt  = B0;
            end
         end
         ST_RUN: begin
            w_set_ill = (r_beat == B3) && w_bad_low;
            if (w_expire) begin
               w_state_nxt = ST_HALT;
            end else if ((r_beat == B3) && w_is_halt) begin
               w_state_nxt = ST_HALT;
            end else if (!w_stall) begin
               if (r_beat == last_beat(w_op)) begin
                  w_done      = 1'b1;
                  w_beat_nxt  = B0;
                  w_state_nxt = run ? ST_RUN : ST_IDLE;
               end else begin
                  w_beat_nxt = r_beat + 3'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_beat     <= B0;
         r_cond     <= 1'b0;
         r_b3_first <= 1'b0;
         r_bus_err  <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_beat     <= w_beat_nxt;
         r_b3_first <= (w_state_nxt == ST_RUN) && (w_beat_nxt == B3) && (r_beat != B3);
         if (r_b3_first) r_cond    <= bus.z;
         if (w_expire)   r_bus_err <= 1'b1;
         if (w_set_ill)  r_illegal <= 1'b1;
      end
   end

   assign instr_done = w_done;
   assign halted     = (r_state == ST_HALT);
   assign bus_err    = r_bus_err;
   assign illegal    = r_illegal;
   assign beat       = r_beat;
endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cpu_ctrl_seq                                            |
// | Description : Directed self-checking bench for cpu_ctrl_seq. Inputs are  |
// |               driven 1 time unit after the rising edge, outputs sampled  |
// |               a further unit later.                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cpu_ctrl_seq;
   logic       clk = 1'b0;
   logic       reset, run, step;
   logic       instr_done, halted, bus_err, illegal;
   logic [2:0] beat;
   int         vectors = 0;
   int         errs    = 0;

   // One-hot positions of the enables in the packed view below.
   localparam logic [20:0] PCBUS  = 21'(1) << 20, R0BUS  = 21'(1) << 19;
   localparam logic [20:0] R1BUS  = 21'(1) << 18, DRLBUS = 21'(1) << 17;
   localparam logic [20:0] DRHBUS = 21'(1) << 16, TRBUS  = 21'(1) << 15;
   localparam logic [20:0] MEMBUS = 21'(1) << 14, BUSMEM = 21'(1) << 13;
   localparam logic [20:0] R0LOAD = 21'(1) << 12, R1LOAD = 21'(1) << 11;
   localparam logic [20:0] ZLOAD  = 21'(1) << 10, XLOAD  = 21'(1) << 9;
   localparam logic [20:0] ARLOAD = 21'(1) << 8,  DRLOAD = 21'(1) << 7;
   localparam logic [20:0] IRLOAD = 21'(1) << 6,  TRLOAD = 21'(1) << 5;
   localparam logic [20:0] PCLOAD = 21'(1) << 4,  PCINC  = 21'(1) << 3;
   localparam logic [20:0] ARINC  = 21'(1) << 2,  READ   = 21'(1) << 1;
   localparam logic [20:0] WRITE  = 21'(1);
   localparam logic [20:0] F0 = PCBUS | ARLOAD;
   localparam logic [20:0] F1 = READ | MEMBUS | DRLOAD | PCINC;
   localparam logic [20:0] F2 = PCBUS | ARLOAD | IRLOAD;

   cpu_ctrl_seq_if #(.DW(8)) bus ();

   cpu_ctrl_seq #(.DW(8), .TIMEOUT(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .step       (step),
      .bus        (bus.master),
      .instr_done (instr_done),
      .halted     (halted),
      .bus_err    (bus_err),
      .illegal    (illegal),
      .beat       (beat)
   );

   logic [20:0] en;
   assign en = {bus.pcbus, bus.r0bus, bus.r1bus, bus.drlbus, bus.drhbus, bus.trbus,
                bus.membus, bus.busmem, bus.r0load, bus.r1load, bus.zload, bus.xload,
                bus.arload, bus.drload, bus.irload, bus.trload, bus.pcload,
                bus.pcinc, bus.arinc, bus.read, bus.write};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Check {beat, instr_done, enables} for the current cycle, then advance.
   task automatic cyc(input string tag, input logic [2:0] b, input logic d,
                      input logic [20:0] e);
      #1;
      chk(tag, 32'({beat, instr_done, en}), 32'({b, d, e}));
      nxt();
   endtask

   task automatic fetch(input string tag);
      cyc({tag, "-b0"}, 3'd0, 1'b0, F0);
      cyc({tag, "-b1"}, 3'd1, 1'b0, F1);
      cyc({tag, "-b2"}, 3'd2, 1'b0, F2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1'b0; run = 1'b0; step = 1'b0;
      bus.ir = 8'h00; bus.z = 1'b0; bus.mem_ready = 1'b1;
      #1;
      chk("rst-outs", 32'({beat, instr_done, en}), 32'h0);
      chk("rst-flags", 32'({halted, bus_err, illegal, bus.alus}), 32'h0);
      nxt(); nxt();
      reset = 1'b1;

      // ADD free-running, then run dropped: a NOP completes and goes idle.
      run = 1'b1; bus.ir = 8'h10;
      cyc("add-idle", 3'd0, 1'b0, '0);
      fetch("add");
      cyc("add-b3", 3'd3, 1'b0, R0BUS | XLOAD);
      #1; chk("add-alus", 32'(bus.alus), 32'h1);
      cyc("add-b4", 3'd4, 1'b1, R1BUS | R0LOAD | ZLOAD);
      run = 1'b0; bus.ir = 8'h00;
      fetch("nop");
      cyc("nop-b3", 3'd3, 1'b1, '0);
      cyc("nop-idle", 3'd0, 1'b0, '0);

      // LAD with three wait states on b6.
      run = 1'b1; bus.ir = 8'hE0;
      cyc("lad-idle", 3'd0, 1'b0, '0);
      fetch("lad");
      cyc("lad-b3", 3'd3, 1'b0, READ | MEMBUS | DRLOAD | PCINC | ARINC);
      cyc("lad-b4", 3'd4, 1'b0, READ | MEMBUS | DRLOAD | PCINC | TRLOAD);
      cyc("lad-b5", 3'd5, 1'b0, DRHBUS | TRBUS | ARLOAD);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("lad-b6-wait", 3'd6, 1'b0, READ | MEMBUS);
      bus.mem_ready = 1'b1;
      cyc("lad-b6-go", 3'd6, 1'b0, READ | MEMBUS | DRLOAD);
      run = 1'b0;
      #1; chk("lad-alus", 32'(bus.alus), 32'hA);
      cyc("lad-b7", 3'd7, 1'b1, DRLBUS | R0LOAD);
      cyc("lad-idle2", 3'd0, 1'b0, '0);

      // JPZ: z high on first b3 cycle, dropped at b4 -> still taken.
      run = 1'b1; bus.ir = 8'hC0; bus.z = 1'b0;
      cyc("jpz-idle", 3'd0, 1'b0, '0);
      fetch("jpz");
      bus.z = 1'b1;
      cyc("jpz-b3", 3'd3, 1'b0, READ | MEMBUS | DRLOAD | ARINC);
      bus.z = 1'b0;
      cyc("jpz-b4", 3'd4, 1'b0, READ | MEMBUS | DRLOAD | TRLOAD);
      cyc("jpz-b5", 3'd5, 1'b1, DRHBUS | TRBUS | PCLOAD);
      // JPNZ with z=1: not taken.
      bus.ir = 8'hD0; bus.z = 1'b1;
      fetch("jpnz");
      run = 1'b0;
      cyc("jpnz-b3", 3'd3, 1'b0, PCINC);
      cyc("jpnz-b4", 3'd4, 1'b0, PCINC);
      cyc("jpnz-b5", 3'd5, 1'b1, '0);
      cyc("jpnz-idle", 3'd0, 1'b0, '0);

      // Single-step MVR; a step pulse mid-instruction is ignored.
      step = 1'b1; bus.ir = 8'hA0;
      cyc("mvr-idle", 3'd0, 1'b0, '0);
      step = 1'b0;
      cyc("mvr-b0", 3'd0, 1'b0, F0);
      step = 1'b1;
      cyc("mvr-b1", 3'd1, 1'b0, F1);
      step = 1'b0;
      cyc("mvr-b2", 3'd2, 1'b0, F2);
      cyc("mvr-b3", 3'd3, 1'b1, R0BUS | R1LOAD);
      cyc("mvr-idle1", 3'd0, 1'b0, '0);
      cyc("mvr-idle2", 3'd0, 1'b0, '0);

      // Illegal low field executes as NOP and sets the sticky flag.
      #1; chk("ill-pre", 32'(illegal), 32'h0);
      step = 1'b1; bus.ir = 8'h13;
      cyc("ill-idle", 3'd0, 1'b0, '0);
      step = 1'b0;
      fetch("ill");
      #1; chk("ill-alus", 32'(bus.alus), 32'h0);
      cyc("ill-b3", 3'd3, 1'b1, '0);
      #1; chk("ill-set", 32'(illegal), 32'h1);
      cyc("ill-idle2", 3'd0, 1'b0, '0);

      // STO with reset asserted in the middle of the b6 write.
      run = 1'b1; bus.ir = 8'hF0;
      cyc("sto-idle", 3'd0, 1'b0, '0);
      fetch("sto");
      cyc("sto-b3", 3'd3, 1'b0, READ | MEMBUS | DRLOAD | PCINC | ARINC);
      cyc("sto-b4", 3'd4, 1'b0, READ | MEMBUS | DRLOAD | PCINC | TRLOAD);
      cyc("sto-b5", 3'd5, 1'b0, DRHBUS | TRBUS | ARLOAD);
      #1; chk("sto-b6", 32'({beat, instr_done, en}), 32'({3'd6, 1'b1, R0BUS | BUSMEM | WRITE}));
      #1; reset = 1'b0; run = 1'b0;
      #1; chk("sto-rst", 32'({beat, instr_done, en}), 32'h0);
      chk("sto-rst-flags", 32'({halted, bus_err, illegal}), 32'h0);
      nxt();
      reset = 1'b1;
      cyc("sto-post", 3'd0, 1'b0, '0);

      // HALT instruction, then stuck until reset.
      step = 1'b1; bus.ir = 8'h0F;
      cyc("hlt-idle", 3'd0, 1'b0, '0);
      step = 1'b0;
      fetch("hlt");
      #1; chk("hlt-b3", 32'({halted, en}), 32'h0);
      nxt();
      #1; chk("hlt-set", 32'({halted, en}), 32'({1'b1, 21'h0}));
      step = 1'b1; run = 1'b1;
      nxt(); nxt();
      step = 1'b0;
      #1; chk("hlt-stuck", 32'({halted, en}), 32'({1'b1, 21'h0}));
      reset = 1'b0; run = 1'b0;
      #1; chk("hlt-rst", 32'(halted), 32'h0);
      nxt();
      reset = 1'b1;

      // 14 stall cycles then ready on the 15th: normal completion.
      run = 1'b1; bus.ir = 8'h00;
      cyc("tmo14-idle", 3'd0, 1'b0, '0);
      cyc("tmo14-b0", 3'd0, 1'b0, F0);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 14; i++) cyc("tmo14-stall", 3'd1, 1'b0, READ | MEMBUS);
      bus.mem_ready = 1'b1;
      cyc("tmo14-ready", 3'd1, 1'b0, F1);
      run = 1'b0;
      cyc("tmo14-b2", 3'd2, 1'b0, F2);
      cyc("tmo14-b3", 3'd3, 1'b1, '0);
      #1; chk("tmo14-noerr", 32'({halted, bus_err}), 32'h0);
      cyc("tmo14-idle2", 3'd0, 1'b0, '0);

      // 15 stall cycles: bus error, halted, strobes dropped.
      run = 1'b1;
      cyc("tmo15-idle", 3'd0, 1'b0, '0);
      cyc("tmo15-b0", 3'd0, 1'b0, F0);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) cyc("tmo15-stall", 3'd1, 1'b0, READ | MEMBUS);
      #1; chk("tmo15-err", 32'({halted, bus_err, en}), 32'({2'b11, 21'h0}));
      bus.mem_ready = 1'b1;
      nxt(); nxt(); nxt();
      #1; chk("tmo15-stuck", 32'({halted, bus_err, en}), 32'({2'b11, 21'h0}));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
`default_nettype wire
